// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int          FRAME_BITS    = 10;
    localparam int          DATA_W        = 8;
    localparam logic [12:0] BPS_T_DEFAULT = 13'd5207;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: request/grant handshake plus line status.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic              en;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        owner;
    logic              busy;
    logic              done;
    logic              txd;

    modport master (
        output en, req, data,
        input  gnt, owner, busy, done, txd
    );

    modport slave (
        input  en, req, data,
        output gnt, owner, busy, done, txd
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: bit_end marks the last clock of each serial bit while run is high.
module uart_bit_timer #(
    parameter logic [12:0] BPS_T = 13'd5207
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    logic [12:0] cnt_q, cnt_d;
    logic        bit_end_q, bit_end_d;

    // Next count; bit_end is pre-decoded from the next count so it leaves a flop.
    always_comb begin
        cnt_d = 13'd0;
        if (!run) begin
            cnt_d = 13'd0;
        end else if (cnt_q == BPS_T) begin
            cnt_d = 13'd0;
        end else begin
            cnt_d = cnt_q + 13'd1;
        end
        bit_end_d = (cnt_d == BPS_T);
    end

    // Counter and decoded bit_end registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 13'd0;
            bit_end_q <= (BPS_T == 13'd0);
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between NREQ byte requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NREQ  = 4,
    parameter logic [12:0] BPS_T = BPS_T_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              txd_q, txd_d;

    logic              run_s;
    logic              bit_end_s;
    logic              arb_ok_s;
    logic [2:0]        winner_s;
    logic [2:0]        ptr_next_s;

    // First set request at or above pointer p, wrapping modulo NREQ.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [2:0]      w;
        logic            found;
        logic [NREQ-1:0] rot;
        int              idx;
        w     = 3'd0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(p) + off) % NREQ;
            rot = r >> idx;
            if (!found && rot[0]) begin
                w     = 3'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    assign run_s = (state_q != IDLE);

    uart_bit_timer #(
        .BPS_T (BPS_T)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run_s),
        .bit_end (bit_end_s)
    );

    assign winner_s   = rr_pick(bus.req, ptr_q);
    assign ptr_next_s = (winner_s == 3'(NREQ - 1)) ? 3'd0 : (winner_s + 3'd1);
    assign arb_ok_s   = ((state_q == IDLE) || ((state_q == STOP) && bit_end_s))
                        && bus.en && (bus.req != {NREQ{1'b0}});

    // Frame sequencing; a grant overrides the stop-bit return to IDLE for back-to-back frames.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        txd_d     = txd_q;
        gnt_d     = {NREQ{1'b0}};
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    txd_d     = shreg_q[0];
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'(DATA_W - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        txd_d     = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase

        if (arb_ok_s) begin
            gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
            shreg_d = DATA_W'(bus.data >> {winner_s, 3'b000});
            owner_d = winner_s;
            ptr_d   = ptr_next_s;
            state_d = START;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            gnt_d = {NREQ{1'b0}};
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= {DATA_W{1'b0}};
            bit_idx_q <= 3'd0;
            owner_q   <= 3'd0;
            ptr_q     <= 3'd0;
            gnt_q     <= {NREQ{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            txd_q     <= txd_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model plus directed and random stimulus.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int          NREQ      = 4;
    localparam logic [12:0] BPS       = 13'd3;
    localparam int          CPB       = 4;
    localparam int          FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_on = 1'b0;
    logic [3:0] hold = 4'b0000;
    int vectors = 0;
    int miscompares = 0;
    int gnt_log[$];
    logic done_log[$];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .BPS_T(BPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic bit_at(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (bit_at(32'(v), i)) return i;
        return -1;
    endfunction

    // Reference: winner is the first requester at or after the pointer, modulo NREQ.
    function automatic int rr_ref(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (bit_at(32'(r), (p + k) % NREQ)) return (p + k) % NREQ;
        return -1;
    endfunction

    // Line level from the number of cycles elapsed since the grant edge.
    function automatic logic exp_txd(input logic busy, input int el, input logic [7:0] b);
        int n;
        n = el / CPB;
        if (!busy) return 1'b1;
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return bit_at(32'(b), n - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    logic       m_busy, m_done;
    int         m_el, m_owner, m_ptr, m_win;
    logic [7:0] m_byte;
    logic [3:0] m_gnt;
    logic       m_end, m_free;

    assign m_end  = m_busy && (m_el == FRAME_CYC - 1);
    assign m_free = !m_busy || m_end;
    always_comb m_win = rr_ref(bus.req, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_el <= 0; m_owner <= 0;
            m_ptr <= 0; m_byte <= 8'h00; m_gnt <= 4'b0000;
        end else begin
            m_done <= m_end;
            if (m_free && bus.en && m_win >= 0) begin
                m_gnt   <= 4'(32'd1 << m_win);
                m_owner <= m_win;
                m_byte  <= 8'(bus.data >> (8 * m_win));
                m_ptr   <= (m_win + 1) % NREQ;
                m_busy  <= 1'b1;
                m_el    <= 0;
            end else begin
                m_gnt <= 4'b0000;
                if (m_end) m_busy <= 1'b0;
                else if (m_busy) m_el <= m_el + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("gnt", 32'(bus.gnt), 32'(m_gnt));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("txd", 32'(bus.txd), 32'(exp_txd(m_busy, m_el, m_byte)));
            if (m_busy) check("owner", 32'(bus.owner), 32'(m_owner));
            if (bus.gnt != 4'b0000) begin
                gnt_log.push_back(onehot_idx(bus.gnt));
                done_log.push_back(bus.done);
            end
        end
    end

    // One cycle; requesters drop req once their gnt is seen unless told to hold.
    task automatic tick();
        @(negedge clk);
        bus.req = bus.req & ~(bus.gnt & ~hold);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = 4'b0000; bus.en = 1'b1; hold = 4'b0000;
        tick();
        rst = 1'b0;
        gnt_log.delete(); done_log.delete();
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        bus.data = (bus.data & ~(32'hFF << (8 * i))) | (32'(b) << (8 * i));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy || bus.req != 4'b0000) && n < budget) begin tick(); n++; end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic collect(input int want, input int budget);
        int n = 0;
        while (gnt_log.size() < want && n < budget) begin tick(); n++; end
        check("grant_count", 32'(gnt_log.size()), 32'(want));
    endtask

    // Single frame from idle with the full expected line pattern (bit b of bits = frame bit b).
    task automatic run_frame(input int idx, input logic [7:0] b, input logic [9:0] bits);
        set_byte(idx, b);
        bus.req = 4'(32'd1 << idx);
        tick();
        check("frame_gnt", 32'(bus.gnt), 32'd1 << idx);
        for (int c = 0; c < FRAME_CYC; c++) begin
            check("frame_txd", 32'(bus.txd), 32'(bit_at(32'(bits), c / CPB)));
            tick();
        end
        check("frame_done", 32'(bus.done), 32'd1);
        check("frame_busy_end", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        int         pre;
        logic [3:0] req;
        logic [3:0] exp_gnt;
    } arb_vec_t;

    arb_vec_t tbl [10];

    initial begin
        int n_g, n_d;
        tbl[0] = '{-1, 4'b0001, 4'b0001};
        tbl[1] = '{-1, 4'b1111, 4'b0001};
        tbl[2] = '{-1, 4'b1000, 4'b1000};
        tbl[3] = '{-1, 4'b1001, 4'b0001};
        tbl[4] = '{ 0, 4'b0001, 4'b0001};
        tbl[5] = '{ 0, 4'b0101, 4'b0100};
        tbl[6] = '{ 1, 4'b0011, 4'b0001};
        tbl[7] = '{ 2, 4'b1111, 4'b1000};
        tbl[8] = '{ 3, 4'b1110, 4'b0010};
        tbl[9] = '{ 2, 4'b0110, 4'b0010};

        bus.en = 1'b1; bus.req = 4'b0000; bus.data = 32'h0;
        @(posedge clk);
        mon_on = 1'b1;
        tick();
        check("rst_txd", 32'(bus.txd), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        rst = 1'b0;

        // Arbitration table: optional priming frame moves the pointer to pre+1.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            if (tbl[v].pre >= 0) run_frame(tbl[v].pre, 8'h55, 10'b1010101010);
            for (int i = 0; i < NREQ; i++) set_byte(i, 8'(8'h10 * (i + 1)));
            bus.req = tbl[v].req;
            tick();
            check("tbl_gnt", 32'(bus.gnt), 32'(tbl[v].exp_gnt));
            bus.req = 4'b0000;
            wait_idle(60);
        end

        // Single request, explicit line pattern and stop/start levels for 00/FF.
        do_reset();
        run_frame(0, 8'hA5, 10'b1101001010);
        run_frame(1, 8'h00, 10'b1000000000);
        run_frame(2, 8'hFF, 10'b1111111110);

        // Contention: all four request, each drops on its grant.
        do_reset();
        set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
        bus.req = 4'b1111;
        collect(4, 200);
        for (int k = 0; k < 4; k++) begin
            check("cont_order", (k < gnt_log.size()) ? 32'(gnt_log[k]) : 32'hFFFF_FFFF, 32'(k));
            if (k > 0) check("cont_done_with_gnt", (k < done_log.size()) ? 32'(done_log[k]) : 32'd0, 32'd1);
        end
        wait_idle(80);

        // Fairness: req[0] and req[2] held continuously.
        do_reset();
        set_byte(0, 8'h5A); set_byte(2, 8'hC3);
        hold = 4'b0101; bus.req = 4'b0101;
        collect(4, 250);
        for (int k = 0; k < 4; k++)
            check("rr_order", (k < gnt_log.size()) ? 32'(gnt_log[k]) : 32'hFFFF_FFFF, (k % 2 == 0) ? 32'd0 : 32'd2);
        hold = 4'b0000; bus.req = 4'b0000;
        wait_idle(80);

        // en gating, then en dropped mid-frame.
        do_reset();
        bus.en = 1'b0; set_byte(1, 8'h6E); bus.req = 4'b0010;
        n_g = 0;
        for (int c = 0; c < 100; c++) begin tick(); if (bus.gnt != 4'b0000) n_g++; end
        check("en_block", 32'(n_g), 32'd0);
        bus.en = 1'b1;
        tick();
        check("en_release_gnt", 32'(bus.gnt), 32'b0010);
        repeat (10) tick();
        bus.en = 1'b0;
        n_d = 0;
        for (int c = 0; c < 40 && n_d == 0; c++) begin tick(); if (bus.done) n_d++; end
        check("en_low_frame_done", 32'(n_d), 32'd1);
        bus.en = 1'b1;

        // Reset during data bit 3, then pointer must restart at 0.
        do_reset();
        set_byte(0, 8'h96); bus.req = 4'b0001;
        tick();
        check("rst_mid_gnt", 32'(bus.gnt), 32'b0001);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_txd", 32'(bus.txd), 32'd1);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_gnt0", 32'(bus.gnt), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        n_d = 0;
        for (int c = 0; c < 50; c++) begin tick(); if (bus.done) n_d++; end
        check("rst_mid_no_done", 32'(n_d), 32'd0);
        set_byte(3, 8'h3C);
        bus.req = 4'b1001;
        tick();
        check("rst_ptr_zero", 32'(bus.gnt), 32'b0001);
        wait_idle(120);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            tick();
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 24) == 0) bus.en = ~bus.en;
            for (int i = 0; i < NREQ; i++) begin
                if (!bit_at(32'(bus.req), i) && $urandom_range(0, 7) == 0) begin
                    set_byte(i, 8'($urandom_range(0, 255)));
                    bus.req = bus.req | 4'(32'd1 << i);
                end
            end
        end
        rst = 1'b0; bus.en = 1'b1;
        tick();
        bus.req = 4'b0000;
        wait_idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between NREQ byte requesters using round-robin arbitration. The block sequences each 8N1 frame (start, 8 data LSB-first, stop) from an internal bit timer. It sits between the per-function byte producers (command echo, status, debug) and the board TXD pin. It replaces per-producer transmitters that would otherwise contend for the pin.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- BPS_T, 13'd5207: bit period minus one, in clk cycles (5208 cycles per bit)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; low blocks new grants, an in-flight frame completes
- req  in  NREQ  per-requester request; held high until the matching gnt bit is seen
- data  in  8*NREQ  byte for requester i at data[8*i+7 : 8*i]; stable while req[i] is high
- gnt  out  NREQ  registered one-hot, 1-cycle pulse: byte i captured
- owner  out  3  index of the requester whose frame is on the line; valid while busy
- busy  out  1  high from the grant edge until the end of the stop bit
- done  out  1  1-cycle pulse at the end of each stop bit
- txd  out  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, STOP.
- Reset values: state IDLE, txd 1, gnt 0, busy 0, done 0, owner 0, RR pointer 0, bit index 0, timer 0.
- Arbitration happens at any edge where all three hold: state is IDLE or ending STOP, en is 1, and req is nonzero.
  - Winner is the first set req bit searching from pointer p upward, modulo NREQ.
  - On that edge: gnt[winner] <= 1, shift register <= data of winner, owner <= winner, p <= (winner+1) mod NREQ, state <= START, txd <= 0, busy <= 1, timer <= 0.
- Bit timer counts 0..BPS_T while state != IDLE. bit_end = (timer == BPS_T). The timer wraps to 0 on bit_end.
- START on bit_end: go to DATA, txd <= shreg[0], bit index <= 0.
- DATA on bit_end:
  - Index < 7: shift right, txd <= next bit, index + 1.
  - Index == 7: go to STOP, txd <= 1.
- STOP on bit_end:
  - done <= 1.
  - If the arbitration conditions hold, grant immediately (back-to-back, no idle cycle).
  - Otherwise state <= IDLE and busy <= 0.
- When en is low, no grant occurs. Requests wait; the pointer does not move.
- req bits not granted are ignored in the cycle gnt is high for another requester. Only one gnt bit is ever set.
- A requester whose req stays high after its gnt is treated as a new request. It is served again only after other pending requesters, per round robin.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives gnt high and txd low during cycle k+1.
- Frame length: exactly 10*(BPS_T+1) cycles from the grant edge to the done edge.
- Start, each data bit and stop each last BPS_T+1 cycles.
- Back-to-back frames: the next start bit begins on the same edge as done. Frame period is 10*(BPS_T+1).
- done and gnt can be high in the same cycle (back-to-back case).
- rst mid-frame: on the next edge all outputs take their reset values. txd returns high, which truncates the frame. No done pulse.
- en deasserted mid-frame: has no effect until the next arbitration point.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - FRAME_BITS = 10;
  - the default BPS_T;
  - the data width constant 8.
- Sub-module uart_bit_timer (inputs clk, rst, run; parameter BPS_T; output bit_end) holds the counter. The FSM, shifter and RR pointer stay in uart_tx_arbiter.

## Test plan
Benches use BPS_T=3 (4 cycles per bit, 40 cycles per frame).
- Single request: req=4'b0001, data0=8'hA5 → gnt=0001 one cycle later; txd reads 0,1,0,1,0,0,1,0,1,1 per 4 cycles; done 40 cycles after the grant edge; busy returns to 0.
- Contention: all 4 req high with distinct bytes 8'h11/22/33/44, req[i] dropped after gnt[i] → grant order 0,1,2,3; four contiguous frames of 40 cycles each; owner tracks the grant order; done coincides with the next gnt.
- Round-robin fairness: req[0] and req[2] held high continuously → grants alternate 0,2,0,2; neither requester is starved.
- en gating: en=0 with req=0010 → no gnt for 100 cycles; en=1 → gnt=0010 on the next cycle. Dropping en mid-frame still lets the frame finish with done.
- Reset mid-frame: assert rst during data bit 3 → next cycle txd=1, busy=0, gnt=0, pointer=0, no done. A later req=1000 still yields a correct frame.
- Data byte 8'h00 and 8'hFF → correct start and stop levels; the stop bit is always 1 for the full 4 cycles.
